// File: rtl/udp_filter_pkg.sv
// ---------------------------------------------------------------------------
// udp_filter_pkg
// Shared types and constants for the UDP filter front-end arbiter.
//   arb_state_e   : arbiter FSM states
//   BYTE_W/PORT_W : stream byte width and UDP port width
//   DEF_MAX_BYTES : longest frame the filter's 6-bit byte counter accepts
// ---------------------------------------------------------------------------
package udp_filter_pkg;

    localparam int BYTE_W        = 8;
    localparam int PORT_W        = 16;
    localparam int DEF_MAX_BYTES = 63;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        GAP    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/udp_filter_arbiter_if.sv
// ---------------------------------------------------------------------------
// udp_filter_arbiter_if
// Bundles the per-source request/stream bus and the shared filter-input bus.
//   req_i       : per-source packet-slot request
//   gnt_o       : one-hot grant back to the sources
//   src_valid_i : per-source byte valid
//   src_data_i  : per-source byte, source n at [8n+7:8n]
//   src_port_i  : per-source UDP port to match, source n at [16n+15:16n]
//   flt_valid_o : filter input valid
//   flt_data_o  : filter input byte
//   flt_port_o  : filter udp_port_to_match
// Modports: master = source/stimulus side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface udp_filter_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                        req_i;
    logic [NUM_REQ-1:0]                        gnt_o;
    logic [NUM_REQ-1:0]                        src_valid_i;
    logic [NUM_REQ*udp_filter_pkg::BYTE_W-1:0] src_data_i;
    logic [NUM_REQ*udp_filter_pkg::PORT_W-1:0] src_port_i;
    logic                                      flt_valid_o;
    logic [udp_filter_pkg::BYTE_W-1:0]         flt_data_o;
    logic [udp_filter_pkg::PORT_W-1:0]         flt_port_o;

    modport master (
        output req_i, src_valid_i, src_data_i, src_port_i,
        input  gnt_o, flt_valid_o, flt_data_o, flt_port_o
    );

    modport slave (
        input  req_i, src_valid_i, src_data_i, src_port_i,
        output gnt_o, flt_valid_o, flt_data_o, flt_port_o
    );
endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder: the first requester at or after
// i_ptr (wrapping) wins.
//   i_req    : request vector
//   i_ptr    : round-robin start index
//   o_onehot : one-hot winner (0 when no request)
//   o_idx    : winner index (0 when no request)
//   o_any    : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_onehot,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // One extra bit so ptr + offset (< 2*NUM_REQ) cannot overflow before wrap.
    logic [IDX_W:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!o_any && i_req[w_cand[IDX_W-1:0]]) begin
                o_any                        = 1'b1;
                o_idx                        = w_cand[IDX_W-1:0];
                o_onehot[w_cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/udp_filter_arbiter.sv
// ---------------------------------------------------------------------------
// udp_filter_arbiter
// Packet-atomic round-robin arbiter sharing one UDP filter among NUM_REQ
// byte-stream sources. Grants one source per packet, forwards its bytes with
// one cycle of latency, drives the filter's port-to-match from the grantee's
// config word, truncates frames longer than MAX_BYTES and enforces an idle
// gap of GAP_CYCLES between packets.
//   clk       : clock
//   reset     : synchronous, active-low reset
//   bus       : source/filter bus (slave modport)
//   cur_src_o : index of current or last grantee
//   busy_o    : high in every state except IDLE
//   trunc_o   : one-cycle pulse when a packet is truncated
// ---------------------------------------------------------------------------
module udp_filter_arbiter
    import udp_filter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_BYTES  = DEF_MAX_BYTES,
    parameter int GAP_CYCLES = 2,
    parameter int START_TO   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    udp_filter_arbiter_if.slave        bus,
    output logic [$clog2(NUM_REQ)-1:0] cur_src_o,
    output logic                       busy_o,
    output logic                       trunc_o
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int TMR_MAX = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    arb_state_e          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [IDX_W-1:0]    r_cur_src;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [5:0]          r_byte_cnt;
    logic [TMR_W-1:0]    r_timer;   // shared: start timeout in GRANT, gap length in GAP
    logic                r_flt_valid;
    logic [BYTE_W-1:0]   r_flt_data;
    logic [PORT_W-1:0]   r_flt_port;
    logic                r_trunc;

    logic [BYTE_W-1:0]   w_src_data [NUM_REQ];
    logic [PORT_W-1:0]   w_src_port [NUM_REQ];
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [IDX_W-1:0]    w_next_ptr;
    logic                w_g_valid;
    logic [BYTE_W-1:0]   w_g_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_src_slice
            assign w_src_data[gi] = bus.src_data_i[gi*BYTE_W +: BYTE_W];
            assign w_src_port[gi] = bus.src_port_i[gi*PORT_W +: PORT_W];
        end
    endgenerate

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req    (bus.req_i),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_next_ptr = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

    // Only the grantee's stream is ever looked at.
    assign w_g_valid = bus.src_valid_i[r_cur_src];
    assign w_g_data  = w_src_data[r_cur_src];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_cur_src   <= '0;
            r_rr_ptr    <= '0;
            r_byte_cnt  <= '0;
            r_timer     <= '0;
            r_flt_valid <= 1'b0;
            r_flt_data  <= '0;
            r_flt_port  <= '0;
            r_trunc     <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_flt_valid <= 1'b0;
                    if (w_pick_any) begin
                        r_gnt      <= w_pick_onehot;
                        r_cur_src  <= w_pick_idx;
                        r_flt_port <= w_src_port[w_pick_idx];
                        r_rr_ptr   <= w_next_ptr;
                        r_timer    <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_g_valid) begin
                        r_flt_valid <= 1'b1;
                        r_flt_data  <= w_g_data;
                        r_byte_cnt  <= 6'd1;
                        r_state     <= STREAM;
                    end else if (r_timer == TMR_W'(START_TO - 1)) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                STREAM: begin
                    if (!w_g_valid) begin
                        r_flt_valid <= 1'b0;
                        r_gnt       <= '0;
                        r_timer     <= '0;
                        r_state     <= GAP;
                    end else if (r_byte_cnt == 6'(MAX_BYTES)) begin
                        // Counter holds at MAX_BYTES; the overflowing byte is dropped.
                        r_flt_valid <= 1'b0;
                        r_trunc     <= 1'b1;
                        r_state     <= DRAIN;
                    end else begin
                        r_flt_valid <= 1'b1;
                        r_flt_data  <= w_g_data;
                        r_byte_cnt  <= r_byte_cnt + 6'd1;
                    end
                end
                DRAIN: begin
                    r_flt_valid <= 1'b0;
                    if (!w_g_valid) begin
                        r_gnt   <= '0;
                        r_timer <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    r_flt_valid <= 1'b0;
                    if (r_timer == TMR_W'(GAP_CYCLES - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.flt_valid_o = r_flt_valid;
    assign bus.flt_data_o  = r_flt_data;
    assign bus.flt_port_o  = r_flt_port;
    assign cur_src_o       = r_cur_src;
    assign busy_o          = (r_state != IDLE);
    assign trunc_o         = r_trunc;
endmodule

// File: tb/tb_udp_filter_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udp_filter_arbiter
// Self-checking bench: directed packet slots followed by randomized ones.
// A transaction-level model (requester set, round-robin pointer, packet
// length) predicts the winner, forwarded bytes, truncation and gap length.
// ---------------------------------------------------------------------------
module tb_udp_filter_arbiter;
    import udp_filter_pkg::*;

    localparam int N    = 4;
    localparam int MAXB = 63;
    localparam int GAPC = 2;
    localparam int STO  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    udp_filter_arbiter_if #(.NUM_REQ(N)) bus ();
    logic [1:0] cur_src;
    logic       busy;
    logic       trunc;

    udp_filter_arbiter #(
        .NUM_REQ    (N),
        .MAX_BYTES  (MAXB),
        .GAP_CYCLES (GAPC),
        .START_TO   (STO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cur_src_o (cur_src),
        .busy_o    (busy),
        .trunc_o   (trunc)
    );

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          slot_no = 0;
    int          m_ptr   = 0;          // model round-robin pointer
    bit [N-1:0]  pending = '0;         // model: sources with a packet waiting
    logic [15:0] next_port [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (slot %0d): got 0x%0h, expected 0x%0h", tag, slot_no, obs, exp);
        end
    endtask

    // First requester at or after ptr, wrapping.
    function automatic int model_pick(input bit [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Drive all source streams: random noise everywhere, grantee w gets (wv, wd).
    task automatic drive(input int w, input logic wv, input logic [7:0] wd, input bit scramble);
        logic [N-1:0]    v;
        logic [N*8-1:0]  d;
        logic [N*16-1:0] p;
        for (int i = 0; i < N; i++) begin
            v[i]         = 1'($urandom);
            d[i*8 +: 8]  = 8'($urandom);
            p[i*16 +: 16] = scramble ? 16'($urandom) : next_port[i];
        end
        if (w >= 0) begin
            v[w]        = wv;
            d[w*8 +: 8] = wd;
        end
        bus.src_valid_i = v;
        bus.src_data_i  = d;
        bus.src_port_i  = p;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"},   bus.gnt_o, 0);
        check_eq({tag, "_valid"}, bus.flt_valid_o, 0);
        check_eq({tag, "_data"},  bus.flt_data_o, 0);
        check_eq({tag, "_port"},  bus.flt_port_o, 0);
        check_eq({tag, "_src"},   cur_src, 0);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_trunc"}, trunc, 0);
    endtask

    // One packet slot. len = 0 means the grantee never sends.
    task automatic do_slot(input bit [N-1:0] add, input int len, input bit keep, input int rst_after);
        int          w;
        int          cnt;
        int          d;
        bit          bad;
        logic [15:0] port_exp;
        logic [7:0]  b;
        logic [N-1:0] gnt_exp;

        slot_no++;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("idle_wait", busy, 0);

        pending   = pending | add;
        w         = model_pick(pending, m_ptr);
        bus.req_i = pending;
        drive(-1, 1'b0, 8'h00, 1'b0);
        port_exp  = next_port[w];
        gnt_exp   = '0;
        gnt_exp[w] = 1'b1;
        @(negedge clk);
        check_eq("gnt", bus.gnt_o, gnt_exp);
        check_eq("cur_src", cur_src, w);
        check_eq("port_at_grant", bus.flt_port_o, port_exp);
        check_eq("valid_at_grant", bus.flt_valid_o, 0);
        check_eq("busy_at_grant", busy, 1);
        m_ptr = (w + 1) % N;
        if (!keep) pending[w] = 1'b0;
        bus.req_i = pending;

        if (len == 0) begin
            cnt = 1;
            bad = 1'b0;
            while (cnt <= STO + 4) begin
                drive(w, 1'b0, 8'h00, 1'b1);
                @(negedge clk);
                if (bus.flt_valid_o !== 1'b0) bad = 1'b1;
                if (bus.gnt_o === '0) break;
                cnt++;
            end
            check_eq("timeout_len", cnt, STO);
            check_eq("timeout_fwd", bad, 0);
            check_eq("timeout_idle", busy, 0);
            $display("slot %0d: src %0d timed out after %0d cycles", slot_no, w, cnt);
            return;
        end

        d   = $urandom_range(0, 6);
        bad = 1'b0;
        repeat (d) begin
            drive(w, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            if (bus.flt_valid_o !== 1'b0 || bus.gnt_o !== gnt_exp) bad = 1'b1;
        end
        check_eq("pre_data_quiet", bad, 0);

        for (int p = 1; p <= len; p++) begin
            b = 8'($urandom);
            drive(w, 1'b1, b, 1'b1);
            @(negedge clk);
            if (p <= MAXB) begin
                check_eq("byte_valid", bus.flt_valid_o, 1);
                check_eq("byte_data", bus.flt_data_o, b);
            end else begin
                check_eq("drain_valid", bus.flt_valid_o, 0);
            end
            check_eq("trunc", trunc, (p == MAXB + 1) ? 1 : 0);
            check_eq("port_hold", bus.flt_port_o, port_exp);
            if (p == rst_after) begin
                reset = 1'b0;
                drive(w, 1'b1, 8'($urandom), 1'b1);
                @(negedge clk);
                check_all_zero("rst_mid");
                reset           = 1'b1;
                pending         = '0;
                m_ptr           = 0;
                bus.req_i       = '0;
                bus.src_valid_i = '0;
                $display("slot %0d: src %0d reset after byte %0d", slot_no, w, p);
                return;
            end
        end

        drive(w, 1'b0, 8'($urandom), 1'b1);
        @(negedge clk);
        check_eq("eop_valid", bus.flt_valid_o, 0);
        check_eq("gap_gnt", bus.gnt_o, 0);
        check_eq("eop_trunc", trunc, 0);
        cnt = 1;
        bad = 1'b0;
        while (busy === 1'b1 && cnt < 20) begin
            drive(-1, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            if (bus.gnt_o !== '0 || bus.flt_valid_o !== 1'b0 || bus.flt_port_o !== port_exp) bad = 1'b1;
            cnt++;
        end
        check_eq("gap_len", cnt, GAPC + 1);
        check_eq("gap_quiet", bad, 0);
        $display("slot %0d: src %0d len %0d port %0d fwd %0d", slot_no, w, len, port_exp,
                 (len > MAXB) ? MAXB : len);
    endtask

    initial begin
        bit [N-1:0] add;
        int         r;
        int         len;

        bus.req_i       = '0;
        bus.src_valid_i = '0;
        bus.src_data_i  = '0;
        bus.src_port_i  = '0;
        for (int i = 0; i < N; i++) next_port[i] = 16'($urandom);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // All four request continuously: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) next_port[i] = 16'($urandom);
            do_slot((k == 0) ? 4'b1111 : 4'b0000, 42, 1'b1, -1);
            check_eq("rotation", cur_src, k % N);
        end
        pending = '0;

        // Single source 0, port 1234, 50 bytes.
        next_port[0] = 16'd1234;
        do_slot(4'b0001, 50, 1'b0, -1);

        // Oversize frame from source 2.
        do_slot(4'b0100, 70, 1'b0, -1);

        // Source 1 never sends while source 2 waits.
        do_slot(4'b0110, 0, 1'b0, -1);
        do_slot(4'b0000, 20, 1'b0, -1);

        // Reset after byte 20, then the pointer must restart at 0.
        do_slot(4'b0100, 50, 1'b0, 20);
        do_slot(4'b1010, 30, 1'b0, -1);
        do_slot(4'b0000, 50, 1'b0, -1);

        // Source 0 drops its request at grant while source 1 waits.
        do_slot(4'b0011, 30, 1'b0, -1);
        do_slot(4'b0000, 25, 1'b0, -1);

        // Lone requester wins back-to-back.
        do_slot(4'b0100, 10, 1'b1, -1);
        do_slot(4'b0000, 10, 1'b0, -1);

        // Randomized slots.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) next_port[i] = 16'($urandom);
            add = N'($urandom);
            if ((pending | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
            r   = $urandom_range(0, 9);
            len = (r == 0) ? 0 : $urandom_range(1, 80);
            do_slot(add, len, 1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/udp_filter_arbiter.md
# udp_filter_arbiter

Packet-atomic round-robin arbiter that shares one `udp_packet_filter` instance among `NUM_REQ` byte-stream sources. It grants one source at a time and muxes that source's valid/data stream onto the filter input. It drives the filter's `udp_port_to_match` from a per-source config word and enforces an idle gap between packets. Oversize packets are truncated at the filter's byte-counter limit.

## Interface
- `NUM_REQ`, 4: number of requesting sources (2..8).
- `MAX_BYTES`, 63: longest frame forwarded; bytes beyond this are dropped.
- `GAP_CYCLES`, 2: idle cycles forced on `flt_valid_o` between packets (≥1).
- `START_TO`, 16: cycles a grantee may take to present its first byte.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_i`  in  NUM_REQ  source n requests a packet slot.
- `gnt_o`  out  NUM_REQ  one-hot grant; 0 when no grant.
- `src_valid_i`  in  NUM_REQ  per-source byte valid; a packet is a contiguous run of high cycles.
- `src_data_i`  in  NUM_REQ*8  per-source byte; source n occupies bits [8n+7:8n].
- `src_port_i`  in  NUM_REQ*16  per-source UDP destination port to match.
- `flt_valid_o`  out  1  valid to filter input stream.
- `flt_data_o`  out  8  data to filter input stream.
- `flt_port_o`  out  16  drives filter `udp_port_to_match`.
- `cur_src_o`  out  $clog2(NUM_REQ)  index of current or last grantee.
- `busy_o`  out  1  high in every state except IDLE.
- `trunc_o`  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States:
  - **IDLE**: no grant held.
  - **GRANT**: grant issued; waiting for the grantee's first byte.
  - **STREAM**: forwarding the grantee's bytes.
  - **DRAIN**: discarding the remainder of an oversize packet.
  - **GAP**: forcing the inter-packet idle period.
- **IDLE**: if any `req_i` is high, pick the first requester at or after `rr_ptr` (wrapping), then:
  - assert its `gnt_o`;
  - latch its `src_port_i` into `flt_port_o` and its index into `cur_src_o`;
  - set `rr_ptr` to the index + 1, mod `NUM_REQ`;
  - go to GRANT.
- **GRANT**: if the grantee's valid is high, go to STREAM and forward that byte; this is byte 1. If `START_TO` cycles pass with no valid, drop the grant and go to IDLE; nothing is forwarded.
- **STREAM**:
  - Forward each grantee byte; count bytes in a 6-bit `byte_cnt`.
  - Valid low ends the packet: go to GAP.
  - If valid is still high after `byte_cnt` = `MAX_BYTES`, the byte is not forwarded, `trunc_o` pulses, and the state goes to DRAIN.
- **DRAIN**: keep `flt_valid_o` = 0 and wait for the grantee's valid to go low, then go to GAP.
- **GAP**: `gnt_o` is 0 from GAP entry. After `GAP_CYCLES` cycles, go to IDLE.
- A grant holds until the packet ends, even if the source drops `req_i` mid-packet.
- Inputs from non-granted sources are ignored in all states.
- `flt_port_o` stays stable from grant until the next grant; it never changes while `flt_valid_o` is high or during GAP.
- A source that is the only requester may win back-to-back; it still gets the GAP.
- Reset (`reset` = 0 at a `posedge clk`), in any state including mid-packet:
  - state = IDLE, `rr_ptr` = 0, `byte_cnt` = 0;
  - `gnt_o` = 0, `flt_valid_o` = 0, `flt_data_o` = 0, `flt_port_o` = 0, `cur_src_o` = 0;
  - `busy_o` = 0, `trunc_o` = 0.

## Timing
- Grant: `req_i` sampled high in IDLE at edge t gives `gnt_o` high after edge t.
- Config before data: `flt_port_o` is valid from the same edge as `gnt_o`, at least one cycle before the first `flt_valid_o`.
- Datapath: fully registered, 1-cycle latency. A grantee byte sampled at edge k appears on `flt_valid_o`/`flt_data_o` after edge k.
- End of packet: after the last byte, `flt_valid_o` falls exactly one cycle after the source's valid falls.
- Gap: at least `GAP_CYCLES` + 1 low cycles on `flt_valid_o` separate consecutive packets (the GAP cycles plus the IDLE→GRANT arbitration cycle).
- `trunc_o` asserts in the cycle where byte `MAX_BYTES`+1 would have been forwarded.
- `byte_cnt` never wraps: it saturates at `MAX_BYTES`.
- Fairness: with all sources requesting continuously, grants rotate 0,1,2,3,0,…

## Structure
- Shared package `udp_filter_pkg`:
  - typedef `arb_state_e` (IDLE, GRANT, STREAM, DRAIN, GAP);
  - `BYTE_W` = 8, `PORT_W` = 16;
  - default `MAX_BYTES` = 63, matching the filter's byte-counter limit.
- Sub-module `rr_pick`: combinational rotate-priority encoder taking the request vector and `rr_ptr`, returning a one-hot winner, its index and an any-request flag. The arbiter FSM, counters and output registers stay in the top module.

## Test plan
- Single source 0, port 1234, sends a 50-byte UDP frame:
  - `gnt_o` = 0001 one cycle after the request;
  - `flt_port_o` = 1234 before the first byte;
  - 50 bytes appear on `flt_*`, each 1 cycle delayed and in order;
  - GAP of 2 cycles, then IDLE.
- All four sources request continuously, each sending a 42-byte frame: grants go 0,1,2,3,0. `flt_port_o` switches only between packets. There are ≥3 idle cycles between frames.
- Source 2 sends 70 bytes:
  - exactly 63 bytes are forwarded;
  - `trunc_o` pulses once on byte 64;
  - `flt_valid_o` stays low until source valid drops, then GAP.
- Source 1 is granted but never asserts valid: the grant is released after 16 cycles, no `flt_valid_o` is seen, and source 2 (pending) is granted next.
- Reset asserted after byte 20 of a frame:
  - all outputs are 0 at the next edge;
  - `rr_ptr` = 0;
  - a subsequent 50-byte frame from source 3 passes intact.
- Source 0 drops `req_i` mid-packet while source 1 requests: source 0's packet completes, the gap is honoured, then `gnt_o` = 0010.
